// File: rtl/a0_trace_fifo.sv
// Trace capture of the CPU a0 register: each enabled change of a0 is stored with a
// free-running cycle stamp in a first-word-fall-through FIFO drained by valid/ready.
module a0_trace_fifo #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned Depth      = 16,
  parameter int unsigned StampWidth = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic                         clear_i,
  input  logic [DataWidth-1:0]         a0_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DataWidth-1:0]         out_data_o,
  output logic [StampWidth-1:0]        out_stamp_o,
  output logic [$clog2(Depth):0]       count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [15:0]                  dropped_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [DataWidth-1:0]  mem_data_q  [Depth];
  logic [StampWidth-1:0] mem_stamp_q [Depth];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [15:0]           dropped_q, dropped_d;
  logic [DataWidth-1:0]  last_a0_q, last_a0_d;
  logic [StampWidth-1:0] stamp_q, stamp_d;

  logic pop, change, push, drop;

  // A full FIFO still accepts an event when the head leaves in the same cycle.
  assign pop    = out_ready_i && !empty_q;
  assign change = en_i && (a0_i != last_a0_q);
  assign push   = change && (!full_q || pop);
  assign drop   = change && full_q && !pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dropped_d = dropped_q;
    last_a0_d = last_a0_q;
    stamp_d   = stamp_q + StampWidth'(1);

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
    if (drop && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;
    if (en_i) last_a0_d = a0_i;

    if (clear_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      dropped_d = '0;
      last_a0_d = '0;
      stamp_d   = '0;
    end

    full_d  = (count_d == CntW'(Depth));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      dropped_q <= '0;
      last_a0_q <= '0;
      stamp_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      dropped_q <= dropped_d;
      last_a0_q <= last_a0_d;
      stamp_q   <= stamp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear_i) begin
      mem_data_q[wr_ptr_q]  <= a0_i;
      mem_stamp_q[wr_ptr_q] <= stamp_q;
    end
  end

  // Head is driven from registered state only; out_ready_i never reaches these outputs.
  assign out_valid_o = !empty_q;
  assign out_data_o  = empty_q ? '0 : mem_data_q[rd_ptr_q];
  assign out_stamp_o = empty_q ? '0 : mem_stamp_q[rd_ptr_q];
  assign count_o     = count_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign dropped_o   = dropped_q;

endmodule
